// File: rtl/ram_sdp_be_if.sv
// Bus bundle for ram_sdp_be: the write port, the read port and the read
// response/status signals.
//   master: drives we, w_addr, i_data, be, re, r_addr (and err_inj);
//           receives o_data, o_valid, init_done (and parity_err).
//   slave : the RAM side of the same signals.
// Build option: define RAM_PARITY_EN to add err_inj / parity_err.
interface ram_sdp_be_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
) ();
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic                  we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic [NB-1:0]         be;
  logic                  re;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  init_done;

`ifdef RAM_PARITY_EN
  logic err_inj;
  logic parity_err;

  modport master (
    output we, w_addr, i_data, be, re, r_addr, err_inj,
    input  o_data, o_valid, init_done, parity_err
  );
  modport slave (
    input  we, w_addr, i_data, be, re, r_addr, err_inj,
    output o_data, o_valid, init_done, parity_err
  );
`else
  modport master (
    output we, w_addr, i_data, be, re, r_addr,
    input  o_data, o_valid, init_done
  );
  modport slave (
    input  we, w_addr, i_data, be, re, r_addr,
    output o_data, o_valid, init_done
  );
`endif
endinterface

// File: rtl/ram_sdp_be.sv
// Simple-dual-port synchronous RAM with per-byte write enables, a read latency
// of 1 or 2 cycles with a valid strobe, selectable read-during-write behaviour
// and a self-initialising sweep after reset.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - ram_sdp_be_if.slave: we/w_addr/i_data/be write port, re/r_addr
//          read port, o_data/o_valid read response, init_done status
// Build option: RAM_PARITY_EN adds one even-parity bit per byte lane, the
// err_inj input (inverts stored parity of enabled lanes on a write) and the
// parity_err output aligned with o_valid.
module ram_sdp_be #(
  parameter int unsigned           ADDR_WIDTH   = 4,
  parameter int unsigned           DATA_WIDTH   = 16,
  parameter int unsigned           READ_LATENCY = 1,
  parameter int unsigned           RDW_MODE     = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input logic         clk,
  input logic         rst,
  ram_sdp_be_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  if (DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0) begin : gen_bad_width
    $error("ram_sdp_be: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gen_bad_latency
    $error("ram_sdp_be: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  init_done_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic init_wr, wr_acc, rd_acc;
  // Ports are dead while rst is sampled high, even if init_done is still set.
  assign init_wr = (state_q == StInit) && !rst;
  assign wr_acc  = bus.we && init_done_q && !rst;
  assign rd_acc  = bus.re && init_done_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == '1) begin
            state_q     <= StReady;
            init_done_q <= 1'b1;
          end
        end
        StReady: begin
        end
        default: state_q <= StInit;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[cnt_q] <= INIT_VALUE;
    end else if (wr_acc) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.be[k]) mem[bus.w_addr][8*k +: 8] <= bus.i_data[8*k +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_word;
  always_comb begin
    rd_word = mem[bus.r_addr];
    if (RDW_MODE == 1 && wr_acc && bus.w_addr == bus.r_addr) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.be[k]) rd_word[8*k +: 8] = bus.i_data[8*k +: 8];
      end
    end
  end

`ifdef RAM_PARITY_EN
  function automatic logic [NB-1:0] lane_par(logic [DATA_WIDTH-1:0] w);
    lane_par = '0;
    for (int k = 0; k < NB; k++) lane_par[k] = ^w[8*k +: 8];
  endfunction

  logic [NB-1:0] par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (init_wr) begin
      par_mem[cnt_q] <= lane_par(INIT_VALUE);
    end else if (wr_acc) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.be[k]) par_mem[bus.w_addr][k] <= (^bus.i_data[8*k +: 8]) ^ bus.err_inj;
      end
    end
  end

  logic [NB-1:0] rd_par;
  logic          rd_perr;
  always_comb begin
    rd_par = par_mem[bus.r_addr];
    if (RDW_MODE == 1 && wr_acc && bus.w_addr == bus.r_addr) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.be[k]) rd_par[k] = (^bus.i_data[8*k +: 8]) ^ bus.err_inj;
      end
    end
    rd_perr = |(lane_par(rd_word) ^ rd_par);
  end
`endif

  // Signals feeding the output register, optionally one stage later.
  logic                  pre_valid;
  logic [DATA_WIDTH-1:0] pre_data;
`ifdef RAM_PARITY_EN
  logic                  pre_perr;
`endif

  if (READ_LATENCY == 2) begin : gen_lat2
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
`ifdef RAM_PARITY_EN
    logic                  s1_perr_q;
`endif
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
`ifdef RAM_PARITY_EN
        s1_perr_q  <= 1'b0;
`endif
      end else begin
        s1_valid_q <= rd_acc;
        if (rd_acc) s1_data_q <= rd_word;
`ifdef RAM_PARITY_EN
        s1_perr_q  <= rd_acc && rd_perr;
`endif
      end
    end
    assign pre_valid = s1_valid_q;
    assign pre_data  = s1_data_q;
`ifdef RAM_PARITY_EN
    assign pre_perr  = s1_perr_q;
`endif
  end else begin : gen_lat1
    assign pre_valid = rd_acc;
    assign pre_data  = rd_word;
`ifdef RAM_PARITY_EN
    assign pre_perr  = rd_perr;
`endif
  end

  logic                  o_valid_q;
  logic [DATA_WIDTH-1:0] o_data_q;
`ifdef RAM_PARITY_EN
  logic                  perr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
`ifdef RAM_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      o_valid_q <= pre_valid;
      // o_data holds the last returned word between strobes.
      if (pre_valid) o_data_q <= pre_data;
`ifdef RAM_PARITY_EN
      perr_q    <= pre_valid && pre_perr;
`endif
    end
  end

  assign bus.o_valid   = o_valid_q;
  assign bus.o_data    = o_data_q;
  assign bus.init_done = init_done_q;
`ifdef RAM_PARITY_EN
  assign bus.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_ram_sdp_be.sv
// Two RAM instances share one stimulus stream: dut_a (latency 1, old-data RDW)
// and dut_b (latency 2, new-data RDW). Expected read responses are pushed into
// per-instance queues by a word-level array model and popped by a monitor.
module tb_ram_sdp_be;
  localparam int DEPTH = 16;
  localparam int RL_A = 1;
  localparam int RL_B = 2;
  localparam logic [15:0] INIT_V = 16'h0000;

  typedef struct {
    logic [15:0] data;
    logic        perr;
    int          due;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        t_rst = 1'b1;
  logic        t_we = 1'b0;
  logic [3:0]  t_waddr = '0;
  logic [15:0] t_data = '0;
  logic [1:0]  t_be = '0;
  logic        t_re = 1'b0;
  logic [3:0]  t_raddr = '0;
  logic        t_err = 1'b0;

  ram_sdp_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus_a ();
  ram_sdp_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus_b ();

  assign bus_a.we = t_we;      assign bus_b.we = t_we;
  assign bus_a.w_addr = t_waddr; assign bus_b.w_addr = t_waddr;
  assign bus_a.i_data = t_data;  assign bus_b.i_data = t_data;
  assign bus_a.be = t_be;      assign bus_b.be = t_be;
  assign bus_a.re = t_re;      assign bus_b.re = t_re;
  assign bus_a.r_addr = t_raddr; assign bus_b.r_addr = t_raddr;
`ifdef RAM_PARITY_EN
  assign bus_a.err_inj = t_err; assign bus_b.err_inj = t_err;
`endif

  ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .READ_LATENCY(RL_A), .RDW_MODE(0),
               .INIT_VALUE(INIT_V))
    dut_a (.clk(clk), .rst(t_rst), .bus(bus_a));
  ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .READ_LATENCY(RL_B), .RDW_MODE(1),
               .INIT_VALUE(INIT_V))
    dut_b (.clk(clk), .rst(t_rst), .bus(bus_b));

  logic        ov [2];
  logic [15:0] od [2];
  logic        idn [2];
  logic        pe [2];
  assign ov[0] = bus_a.o_valid;    assign ov[1] = bus_b.o_valid;
  assign od[0] = bus_a.o_data;     assign od[1] = bus_b.o_data;
  assign idn[0] = bus_a.init_done; assign idn[1] = bus_b.init_done;
`ifdef RAM_PARITY_EN
  assign pe[0] = bus_a.parity_err; assign pe[1] = bus_b.parity_err;
`else
  assign pe[0] = 1'b0;             assign pe[1] = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: word array plus a per-lane "parity corrupted" flag.
  logic [15:0] mem_m [DEPTH];
  logic [1:0]  bad_m [DEPTH];
  bit          model_ready = 0;
  int          sweep = 0;
  entry_t      sb [2][$];

  function automatic logic [15:0] merge(logic [15:0] old_w, logic [15:0] new_w,
                                        logic [1:0] be);
    logic [15:0] r;
    r = old_w;
    if (be[0]) r[7:0] = new_w[7:0];
    if (be[1]) r[15:8] = new_w[15:8];
    return r;
  endfunction

  function automatic logic [1:0] merge_bad(logic [1:0] old_b, logic [1:0] be, logic err);
    logic [1:0] r;
    r = old_b;
    if (be[0]) r[0] = err;
    if (be[1]) r[1] = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply the model effects of the coming edge, then advance past it.
  task automatic tick();
    entry_t e;
    if (t_rst) begin
      model_ready = 0;
      sweep = 0;
      for (int d = 0; d < 2; d++) begin
        while (sb[d].size() > 0 && sb[d][$].due > cyc) void'(sb[d].pop_back());
      end
    end else if (!model_ready) begin
      mem_m[sweep] = INIT_V;
      bad_m[sweep] = 2'b00;
      sweep++;
      if (sweep == DEPTH) model_ready = 1;
    end else begin
      if (t_re) begin
        for (int d = 0; d < 2; d++) begin
          e.data = mem_m[t_raddr];
          e.perr = |bad_m[t_raddr];
          if (d == 1 && t_we && t_waddr == t_raddr) begin
            e.data = merge(mem_m[t_raddr], t_data, t_be);
            e.perr = |merge_bad(bad_m[t_raddr], t_be, t_err);
          end
          e.due = cyc + ((d == 0) ? RL_A : RL_B);
          sb[d].push_back(e);
        end
      end
      if (t_we) begin
        mem_m[t_waddr] = merge(mem_m[t_waddr], t_data, t_be);
        bad_m[t_waddr] = merge_bad(bad_m[t_waddr], t_be, t_err);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_io(input logic we, input logic [3:0] wa, input logic [15:0] dat,
                        input logic [1:0] be, input logic re, input logic [3:0] ra);
    t_we = we; t_waddr = wa; t_data = dat; t_be = be; t_re = re; t_raddr = ra;
    t_err = 1'b0;
  endtask

  task automatic idle(input int n);
    set_io(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Release reset and walk the init sweep, checking init_done timing.
  task automatic run_sweep();
    t_rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("init_done_low_a_%0d", i), 32'(idn[0]), 32'd0);
      chk($sformatf("init_done_low_b_%0d", i), 32'(idn[1]), 32'd0);
      set_io(1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
             4'($urandom));
      tick();
    end
    chk("init_done_high_a", 32'(idn[0]), 32'd1);
    chk("init_done_high_b", 32'(idn[1]), 32'd1);
  endtask

  entry_t mon_e;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      while (sb[d].size() > 0 && sb[d][0].due < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_strobe dut%0d: no o_valid at cycle %0d, required data %h",
                 d, sb[d][0].due, sb[d][0].data);
        void'(sb[d].pop_front());
      end
      if (ov[d] === 1'b1) begin
        n_cmp++;
        if (sb[d].size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid dut%0d: o_valid=1 with data %h at cycle %0d, none required",
                   d, od[d], cyc);
        end else begin
          mon_e = sb[d].pop_front();
          if (od[d] !== mon_e.data || mon_e.due != cyc) begin
            n_err++;
            $display("FAIL read_data dut%0d: got %h at cycle %0d, required %h at cycle %0d",
                     d, od[d], cyc, mon_e.data, mon_e.due);
          end
`ifdef RAM_PARITY_EN
          n_cmp++;
          if (pe[d] !== mon_e.perr) begin
            n_err++;
            $display("FAIL parity_err dut%0d: got %b, required %b (cycle %0d)",
                     d, pe[d], mon_e.perr, cyc);
          end
`endif
        end
      end else if (pe[d] === 1'b1) begin
        n_cmp++;
        n_err++;
        $display("FAIL parity_no_valid dut%0d: parity_err=1 while o_valid=0 (cycle %0d)", d, cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 cycles.
    t_rst = 1'b1;
    set_io(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_valid_%0d", d), 32'(ov[d]), 32'd0);
      chk($sformatf("reset_data_%0d", d), 32'(od[d]), 32'd0);
      chk($sformatf("reset_init_done_%0d", d), 32'(idn[d]), 32'd0);
    end

    // Sweep with random ignored traffic, then read the whole array.
    run_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      set_io(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'(i));
      tick();
    end
    idle(3);

    // Fill with i+10, then back-to-back readback.
    for (int i = 0; i < DEPTH; i++) begin
      set_io(1'b1, 4'(i), 16'(i + 10), 2'b11, 1'b0, 4'd0);
      tick();
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_io(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'(i));
      tick();
    end
    idle(3);

    // Byte enables: A5A5 then low lane 34 -> A534.
    set_io(1'b1, 4'd3, 16'hA5A5, 2'b11, 1'b0, 4'd0); tick();
    set_io(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0); tick();
    set_io(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3); tick();
    idle(3);

    // Read-during-write on the same address, then a plain re-read.
    set_io(1'b1, 4'd5, 16'h0011, 2'b11, 1'b0, 4'd0); tick();
    set_io(1'b1, 4'd5, 16'h2222, 2'b10, 1'b1, 4'd5); tick();
    set_io(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5); tick();
    idle(3);

    // Random traffic over a few addresses to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      set_io(1'($urandom), 4'($urandom_range(0, 3)), 16'($urandom), 2'($urandom),
             1'($urandom), 4'($urandom_range(0, 3)));
`ifdef RAM_PARITY_EN
      t_err = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    idle(3);

    // Reset in the middle of reads.
    set_io(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd1); tick();
    set_io(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd2); tick();
    set_io(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
    t_rst = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midreset_valid_%0d", d), 32'(ov[d]), 32'd0);
      chk($sformatf("midreset_init_done_%0d", d), 32'(idn[d]), 32'd0);
    end
    tick();
    run_sweep();
    set_io(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd1); tick();
    idle(3);

`ifdef RAM_PARITY_EN
    set_io(1'b1, 4'd7, 16'h00FF, 2'b01, 1'b0, 4'd0);
    t_err = 1'b1;
    tick();
    set_io(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd7); tick();
    set_io(1'b1, 4'd7, 16'h00FF, 2'b01, 1'b0, 4'd0); tick();
    set_io(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd7); tick();
    idle(3);
`endif

    idle(4);
    chk("drain_a", 32'(sb[0].size()), 32'd0);
    chk("drain_b", 32'(sb[1].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Parametrised simple-dual-port synchronous RAM; successor to the single-port ram1 block.
- Has independent write and read ports, per-byte write enables, and a configurable read latency with a valid strobe.
- Read-during-write behaviour is selectable, and the array self-initialises after reset.
- Used as the general-purpose on-chip buffer memory for datapath blocks.

Parameters:
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 16, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
READ_LATENCY, 1, cycles from read request to o_valid; legal values 1 or 2
RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data (byte-merged)
INIT_VALUE, 0, word written to every address during the init sweep

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous active-high reset
we  input  1  write request
w_addr  input  ADDR_WIDTH  write address
i_data  input  DATA_WIDTH  write data
be  input  NB  byte enables; be[k] covers i_data[8k+7:8k]
re  input  1  read request
r_addr  input  ADDR_WIDTH  read address
o_data  output  DATA_WIDTH  read data
o_valid  output  1  one-cycle strobe per accepted read
init_done  output  1  high once the array is initialised and ports are accepted

Behaviour:
- Reset
  - When rst is sampled high: state INIT, init counter = 0, init_done = 0, o_valid = 0, o_data = 0.
  - All in-flight reads are discarded.
  - Array contents are not guaranteed until the init sweep completes.
- State machine: INIT -> READY.
  - INIT writes INIT_VALUE (all lanes) to address cnt each cycle, cnt 0..DEPTH-1.
  - While rst is held, cnt stays 0.
  - After the cycle that writes DEPTH-1, go to READY; init_done = 1 on the next edge.
  - Exactly DEPTH cycles elapse from the first low-rst edge to init_done.
- During INIT, we and re are ignored: no write, no o_valid.
- Write: when we=1 and init_done=1, at posedge, mem[w_addr] lanes with be[k]=1 take i_data; other lanes are unchanged. we with be=0 is a no-op.
- Read: when re=1 and init_done=1, the request is accepted.
  - READ_LATENCY=1: o_data and o_valid update on the next edge.
  - READ_LATENCY=2: an additional output register stage.
  - Fully pipelined: back-to-back reads every cycle give a strobe every cycle.
- o_data holds the last read word while o_valid=0.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the new lanes where be=1 and old lanes elsewhere.
  - Different addresses: independent.
- Reset mid-operation
  - Pipeline valid bits clear on the reset edge; o_valid = 0 from that edge on.
  - The init sweep restarts from address 0.
- Addresses always wrap within DEPTH; no out-of-range case exists.
- Illegal READ_LATENCY or DATA_WIDTH: elaboration-time $error.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane and written with the data (including during the init sweep).
  - New input err_inj (1 bit): when high with a write, the stored parity of every enabled lane is inverted.
  - New output parity_err (1 bit) is aligned with o_valid: high when any lane of the returned word fails parity, 0 when o_valid=0, reset to 0.
  - RDW_MODE=1 forwarding uses the new parity bits.
- Undefined: no parity storage, no err_inj or parity_err ports, zero area overhead.

Test Plan:
- Init sweep (ADDR_WIDTH=4, DATA_WIDTH=16, INIT_VALUE=16'h0000):
  - Stimulus: rst high 3 cycles, then release.
  - Required: init_done rises 16 cycles after release; reads of addr 0..15 all return 16'h0000; we/re issued before init_done have no effect.
- Fill/readback:
  - Stimulus: write addr i with data i+10 for i = 0..15, be=2'b11; then read 0..15 back-to-back.
  - Required: o_valid continuous for 16 cycles; data 10..25 in order; first strobe exactly READ_LATENCY cycles after the first re (run with 1 and 2).
- Byte enables:
  - Stimulus: write 16'hA5A5 at addr 3; then write 16'h1234 with be=2'b01; read 3.
  - Required: 16'hA534.
- Read-during-write:
  - Stimulus: addr 5 holds 16'h0011; same cycle write 16'h2222 with be=2'b10 and read 5.
  - Required: RDW_MODE=0 returns 16'h0011; RDW_MODE=1 returns 16'h2211; a subsequent read returns 16'h2211.
- Reset mid-read:
  - Stimulus: issue reads at addr 1, 2; assert rst on the cycle after.
  - Required: no o_valid after the reset edge; init_done drops; the sweep restarts; addr 1 reads INIT_VALUE afterwards.
- RAM_PARITY_EN:
  - Stimulus: write 16'h00FF at addr 7 with err_inj=1, be=2'b01; read 7; then rewrite without err_inj and read 7.
  - Required: first read gives parity_err=1 with o_valid and o_data=16'h00FF; second read gives parity_err=0.
